ptp_bridge_fifo_rr_sched: RTL and testbench
===========================================

PTP_BRIDGE_FIFO_RR_SCHED -- requirements
Module: ptp_bridge_fifo_rr_sched

Interface
REQ-001 Parameter NQ, default 4, number of show-ahead input queues, range 2..8.
REQ-002 Parameter DWD, default 64, queue data width.
REQ-003 Parameter QW, default $clog2(NQ), queue-id width; derived, not overridden.
REQ-004 Port clk1  input  1  single clock; all logic rising-edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port q_dout  input  NQ*DWD  show-ahead head word per queue; queue i at bits [i*DWD +: DWD].
REQ-007 Port q_eop  input  NQ  end-of-packet flag of each queue's head word.
REQ-008 Port q_rdempty  input  NQ  per-queue empty.
REQ-009 Port q_rdreq  output  NQ  per-queue pop, combinational, at most one bit high.
REQ-010 Port q_enable  input  NQ  per-queue arbitration enable, quasi-static.
REQ-011 Port out_data  output  DWD  registered output word.
REQ-012 Port out_eop  output  1  registered end-of-packet.
REQ-013 Port out_qid  output  QW  source queue of out_data.
REQ-014 Port out_valid  output  1  output word valid.
REQ-015 Port out_ready  input  1  downstream accept; transfer when out_valid & out_ready.
REQ-016 Port busy  output  1  high while in XFER state.

Function
REQ-017 The FSM SHALL have two states: IDLE and XFER.
REQ-018 In IDLE, eligible set = ~q_rdempty & q_enable; if non-empty, the block SHALL grant the first eligible queue searching (last_ptr+1) mod NQ upward with wrap, register it in grant, and enter XFER next cycle.
REQ-019 In IDLE, q_rdreq SHALL be all zero.
REQ-020 In XFER, q_rdreq[grant] = !q_rdempty[grant] & (out_ready | !out_valid); all other bits zero.
REQ-021 A pop SHALL load out_data/out_eop/out_qid from the granted queue and set out_valid the next cycle (1-cycle latency).
REQ-022 out_valid SHALL clear on out_valid & out_ready with no pop in the same cycle; pop and accept in one cycle keeps out_valid high with new data.
REQ-023 A pop with q_eop[grant]=1 SHALL set last_ptr <= grant and return to IDLE; grant held for the entire packet (no interleaving).
REQ-024 Granted queue empty mid-packet: SHALL stay in XFER, no pop, no timeout.
REQ-025 q_enable[grant] deasserted mid-packet: SHALL finish the packet through eop; queue excluded thereafter.
REQ-026 q_rdreq SHALL never assert to an empty queue (no underflow).
REQ-027 Single eligible queue SHALL be regranted after its eop; one IDLE cycle between packets is permitted.
REQ-028 Out-register stall: out_data/out_eop/out_qid SHALL hold while out_valid & !out_ready.

Reset
REQ-029 On rst: state=IDLE, grant=0, last_ptr=NQ-1 (so queue 0 wins first), out_valid=0, out_eop=0, out_data=0, out_qid=0, busy=0, q_rdreq=0 in the same cycle.
REQ-030 Reset mid-packet SHALL abandon the packet; remaining words popped later as a new packet, no recovery.

Configuration
REQ-031 Macro PTP_BRIDGE_SCHED_STATS_EN, when defined, SHALL add output pkt_cnt [NQ*32] (per-queue eop-pop count, wraps at 2^32, reset 0) and input stats_clr (synchronous clear of all counters, higher priority than increment).
REQ-032 Without PTP_BRIDGE_SCHED_STATS_EN, pkt_cnt and stats_clr SHALL not exist and no counter logic is built.

Structure
REQ-033 Package ptp_bridge_sched_pkg SHALL hold the state enum (IDLE, XFER) and STATS_CW=32.
REQ-034 Sub-module ptp_bridge_rr_pick (combinational rotating priority picker: req, last_ptr -> valid, idx) SHALL be used for REQ-018.

Verification
REQ-035 Reset then q0,q2 each hold a 3-word packet, out_ready=1 -> q0 words, IDLE cycle, q2 words; out_qid 0,0,0,2,2,2.
REQ-036 All 4 queues continuously non-empty with 1-word packets -> grant order 0,1,2,3,0 repeating; no queue served twice before others.
REQ-037 out_ready=0 for 5 cycles mid-packet -> out_data held, exactly one pop before stall, none during stall, no word lost.
REQ-038 q1 goes empty after word 2 of 4 for 10 cycles while q3 non-empty -> busy stays 1, no q3 pop until q1 eop delivered.
REQ-039 rst asserted at word 2 of a 4-word packet -> next cycle out_valid=0, q_rdreq=0, state IDLE; next grant starts from queue 0.
REQ-040 With PTP_BRIDGE_SCHED_STATS_EN: 7 packets from q3, stats_clr pulse, 2 more -> pkt_cnt[3] reads 7 then 0 then 2.

Source files
------------

// File: rtl/ptp_bridge_sched_pkg.sv
// ---------------------------------------------------------------------------
// ptp_bridge_sched_pkg
// Shared definitions for the PTP bridge round-robin FIFO scheduler.
//   state_t  : scheduler FSM states (IDLE waits for an eligible queue,
//              XFER streams one whole packet from the granted queue)
//   STATS_CW : width of each per-queue packet counter (statistics build,
//              enabled by defining PTP_BRIDGE_SCHED_STATS_EN)
// ---------------------------------------------------------------------------
package ptp_bridge_sched_pkg;

    localparam int STATS_CW = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

endpackage

// File: rtl/ptp_bridge_rr_pick.sv
// ---------------------------------------------------------------------------
// ptp_bridge_rr_pick
// Combinational rotating-priority picker. Searches req starting at
// (last_ptr + 1) mod NQ, upward with wrap, and returns the first set bit.
// Ports:
//   req      in  [NQ-1:0]  request vector
//   last_ptr in  [QW-1:0]  most recently served index (lowest priority)
//   valid    out           at least one request present
//   idx      out [QW-1:0]  selected index (0 when valid is low)
// ---------------------------------------------------------------------------
module ptp_bridge_rr_pick
    import ptp_bridge_sched_pkg::*;
#(
    parameter int NQ = 4,
    parameter int QW = $clog2(NQ)
) (
    input  logic [NQ-1:0] req,
    input  logic [QW-1:0] last_ptr,
    output logic          valid,
    output logic [QW-1:0] idx
);

    int cand;

    // Walk the search order backwards so the last hit assigned is the
    // nearest one after last_ptr; no early-exit flag is needed.
    always_comb begin
        // NOTE: every output gets a default before the loop, otherwise a
        // path with no request would infer a latch.
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int i = NQ; i >= 1; i--) begin
            cand = (int'(last_ptr) + i) % NQ;
            if (req[cand]) begin
                valid = 1'b1;
                idx   = QW'(cand);
            end
        end
    end

endmodule

// File: rtl/ptp_bridge_fifo_rr_sched.sv
// ---------------------------------------------------------------------------
// ptp_bridge_fifo_rr_sched
// Packet-level round-robin scheduler draining NQ show-ahead FIFOs into one
// registered output stream. A queue, once granted, keeps the grant until its
// end-of-packet word is popped, so packets never interleave.
//
// Optional build: define PTP_BRIDGE_SCHED_STATS_EN to add per-queue packet
// counters (pkt_cnt) with a synchronous clear (stats_clr).
//
// Ports:
//   clk1       in                 clock, rising edge
//   rst        in                 synchronous active-high reset
//   q_dout     in  [NQ*DWD-1:0]   head word of each queue (queue i at i*DWD)
//   q_eop      in  [NQ-1:0]       end-of-packet flag of each head word
//   q_rdempty  in  [NQ-1:0]       queue empty
//   q_rdreq    out [NQ-1:0]       pop strobe (combinational, one-hot or zero)
//   q_enable   in  [NQ-1:0]       queue may win arbitration
//   out_data   out [DWD-1:0]      registered output word
//   out_eop    out                registered end-of-packet
//   out_qid    out [QW-1:0]       source queue of out_data
//   out_valid  out                output word valid
//   out_ready  in                 downstream accept
//   pkt_cnt    out [NQ*32-1:0]    per-queue eop count (stats build only)
//   stats_clr  in                 clear all counters (stats build only)
//   busy       out                packet transfer in progress
// ---------------------------------------------------------------------------
module ptp_bridge_fifo_rr_sched
    import ptp_bridge_sched_pkg::*;
#(
    parameter  int NQ  = 4,
    parameter  int DWD = 64,
    localparam int QW  = $clog2(NQ)
) (
    input  logic                   clk1,
    input  logic                   rst,
    input  logic [NQ*DWD-1:0]      q_dout,
    input  logic [NQ-1:0]          q_eop,
    input  logic [NQ-1:0]          q_rdempty,
    output logic [NQ-1:0]          q_rdreq,
    input  logic [NQ-1:0]          q_enable,
    output logic [DWD-1:0]         out_data,
    output logic                   out_eop,
    output logic [QW-1:0]          out_qid,
    output logic                   out_valid,
    input  logic                   out_ready,
`ifdef PTP_BRIDGE_SCHED_STATS_EN
    output logic [NQ*STATS_CW-1:0] pkt_cnt,
    input  logic                   stats_clr,
`endif
    output logic                   busy
);

    state_t        state;
    logic [QW-1:0] grant;
    logic [QW-1:0] last_ptr;
    logic [NQ-1:0] eligible;
    logic          pick_valid;
    logic [QW-1:0] pick_idx;
    logic          pop;
    logic          pop_eop;

    assign eligible = ~q_rdempty & q_enable;

    ptp_bridge_rr_pick #(
        .NQ (NQ),
        .QW (QW)
    ) u_pick (
        .req      (eligible),
        .last_ptr (last_ptr),
        .valid    (pick_valid),
        .idx      (pick_idx)
    );

    // Pop only when the granted queue has a word and the output register is
    // free or being drained this cycle. Gating with rst keeps the FIFOs
    // untouched during the reset cycle itself.
    assign pop     = !rst && (state == XFER) && !q_rdempty[grant]
                     && (out_ready || !out_valid);
    assign pop_eop = pop && q_eop[grant];

    always_comb begin
        q_rdreq = '0;
        if (pop) begin
            q_rdreq[grant] = 1'b1;
        end
    end

    assign busy = !rst && (state == XFER);

    // Arbitration FSM. q_enable is only consulted in IDLE, so a queue
    // disabled mid-packet still completes the packet it owns.
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            last_ptr <= QW'(NQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant <= pick_idx;
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (pop_eop) begin
                        last_ptr <= grant;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output register: load on pop, clear valid on accept without a refill,
    // otherwise hold (covers the stall case).
    always_ff @(posedge clk1) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_eop   <= 1'b0;
            out_data  <= '0;
            out_qid   <= '0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_eop   <= q_eop[grant];
            out_data  <= q_dout[int'(grant)*DWD +: DWD];
            out_qid   <= grant;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef PTP_BRIDGE_SCHED_STATS_EN
    // Counters wrap naturally at 2^STATS_CW; clear beats increment.
    always_ff @(posedge clk1) begin
        if (rst || stats_clr) begin
            pkt_cnt <= '0;
        end else if (pop_eop) begin
            pkt_cnt[int'(grant)*STATS_CW +: STATS_CW] <=
                pkt_cnt[int'(grant)*STATS_CW +: STATS_CW] + STATS_CW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_ptp_bridge_fifo_rr_sched.sv
// ---------------------------------------------------------------------------
// tb_ptp_bridge_fifo_rr_sched
// Self-checking bench for ptp_bridge_fifo_rr_sched. The bench owns NQ
// show-ahead FIFO models; a packet-level round-robin model predicts the
// delivered word stream, and per-cycle rules check pop legality, load
// latency, accept/clear and stall hold.
// Define PTP_BRIDGE_SCHED_STATS_EN to also exercise the packet counters.
// ---------------------------------------------------------------------------
module tb_ptp_bridge_fifo_rr_sched;

    localparam int NQ    = 4;
    localparam int DWD   = 64;
    localparam int QW    = $clog2(NQ);
    localparam int DEPTH = 256;

    typedef struct packed {
        logic [QW-1:0]  qid;
        logic           eop;
        logic [DWD-1:0] data;
    } word_t;

    logic              clk1 = 1'b0;
    logic              rst  = 1'b1;
    logic [NQ*DWD-1:0] q_dout = '0;
    logic [NQ-1:0]     q_eop = '0;
    logic [NQ-1:0]     q_rdempty = '1;
    logic [NQ-1:0]     q_rdreq;
    logic [NQ-1:0]     q_enable = '1;
    logic [DWD-1:0]    out_data;
    logic              out_eop;
    logic [QW-1:0]     out_qid;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              busy;
`ifdef PTP_BRIDGE_SCHED_STATS_EN
    logic [NQ*32-1:0]  pkt_cnt;
    logic              stats_clr = 1'b0;
`endif

    always #5 clk1 = ~clk1;

    ptp_bridge_fifo_rr_sched #(
        .NQ  (NQ),
        .DWD (DWD)
    ) dut (
        .clk1      (clk1),
        .rst       (rst),
        .q_dout    (q_dout),
        .q_eop     (q_eop),
        .q_rdempty (q_rdempty),
        .q_rdreq   (q_rdreq),
        .q_enable  (q_enable),
        .out_data  (out_data),
        .out_eop   (out_eop),
        .out_qid   (out_qid),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef PTP_BRIDGE_SCHED_STATS_EN
        .pkt_cnt   (pkt_cnt),
        .stats_clr (stats_clr),
`endif
        .busy      (busy)
    );

    // FIFO models: {eop, data} entries with free-running pointers.
    logic [DWD:0]  fmem [NQ][DEPTH];
    int            fwr [NQ];
    int            frd [NQ];
    int            mrd [NQ];
    int            m_last;
    word_t         exp_q[$];
    word_t         got_q[$];
    int            errors = 0;
    int            checks = 0;
    logic          rand_ready = 1'b0;
    logic          last_pop;
    logic [NQ-1:0] last_rq;

    task automatic drive();
        logic [DWD:0] h;
        for (int i = 0; i < NQ; i++) begin
            if (fwr[i] == frd[i]) begin
                h = '0;
                q_rdempty[i] = 1'b1;
            end else begin
                h = fmem[i][frd[i] % DEPTH];
                q_rdempty[i] = 1'b0;
            end
            q_dout[i*DWD +: DWD] = h[DWD-1:0];
            q_eop[i] = h[DWD];
        end
    endtask

    task automatic push_word(input int q, input logic eop);
        fmem[q][fwr[q] % DEPTH] = {eop, $urandom(), $urandom()};
        fwr[q]++;
        drive();
    endtask

    task automatic push_pkt(input int q, input int len);
        for (int k = 0; k < len; k++) push_word(q, k == len - 1);
    endtask

    task automatic model_start();
        for (int i = 0; i < NQ; i++) mrd[i] = frd[i];
        got_q.delete();
    endtask

    // Packet-level round robin over the FIFO contents present from mrd on.
    task automatic build_exp(input logic [NQ-1:0] en);
        int           p [NQ];
        int           last;
        int           sel;
        int           c;
        bit           any;
        bit           done;
        logic [DWD:0] h;
        word_t        e;
        for (int i = 0; i < NQ; i++) p[i] = mrd[i];
        last = m_last;
        done = 0;
        exp_q.delete();
        while (!done) begin
            any = 0;
            sel = 0;
            for (int k = 1; k <= NQ; k++) begin
                c = (last + k) % NQ;
                if (!any && en[c] && p[c] < fwr[c]) begin
                    any = 1;
                    sel = c;
                end
            end
            if (!any) begin
                done = 1;
            end else begin
                h = '0;
                while (!h[DWD] && p[sel] < fwr[sel]) begin
                    h = fmem[sel][p[sel] % DEPTH];
                    e.qid = QW'(sel);
                    e.eop = h[DWD];
                    e.data = h[DWD-1:0];
                    exp_q.push_back(e);
                    p[sel]++;
                end
                last = sel;
                if (!h[DWD]) done = 1;
            end
        end
        m_last = last;
    endtask

    // One clock cycle with per-cycle rule checks.
    task automatic step();
        logic [NQ-1:0]  rq;
        logic           rs, pv, pr, oe, pe, pop;
        logic [DWD-1:0] od, pd;
        logic [QW-1:0]  oq;
        logic [DWD:0]   h;
        int             pq;
        word_t          w;
        @(negedge clk1);
        rq = q_rdreq; rs = rst; pv = out_valid; pr = out_ready;
        od = out_data; oe = out_eop; oq = out_qid;
        pop = 0; pq = 0; pd = '0; pe = 0;
        if (pv === 1'b1 && pr) begin
            w.qid = oq; w.eop = oe; w.data = od;
            got_q.push_back(w);
        end
        checks++;
        if ($countones(rq) > 1 || (rs && rq !== '0) || (pv === 1'b1 && !pr && rq !== '0)) begin
            errors++;
            $display("FAIL rdreq_rule got=%b (valid=%b ready=%b rst=%b)", rq, pv, pr, rs);
        end
        for (int i = 0; i < NQ; i++) begin
            if (rq[i] === 1'b1) begin
                checks++;
                if (fwr[i] == frd[i]) begin
                    errors++;
                    $display("FAIL underflow queue=%0d got rdreq=1 required 0", i);
                end else begin
                    pop = 1; pq = i;
                    h = fmem[i][frd[i] % DEPTH];
                    pd = h[DWD-1:0]; pe = h[DWD];
                end
            end
        end
        last_rq = rq;
        last_pop = pop;
        @(posedge clk1);
        #1;
        if (pop) frd[pq]++;
        if (rand_ready) out_ready = ($urandom_range(0, 9) < 7);
        drive();
        if (rs) begin
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || q_rdreq !== '0) begin
                errors++;
                $display("FAIL reset_cycle got valid=%b busy=%b rdreq=%b required 0/0/0", out_valid, busy, q_rdreq);
            end
        end else if (pop) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== pd || out_eop !== pe || out_qid !== QW'(pq)) begin
                errors++;
                $display("FAIL load got v=%b d=%h e=%b q=%0d required 1 %h %b %0d", out_valid, out_data, out_eop, out_qid, pd, pe, pq);
            end
        end else if (pv === 1'b1 && pr) begin
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL accept_clear got valid=%b required 0", out_valid);
            end
        end else if (pv === 1'b1) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== od || out_eop !== oe || out_qid !== oq) begin
                errors++;
                $display("FAIL stall_hold got d=%h required %h", out_data, od);
            end
        end
    endtask

    task automatic wait_got(input string name, input int n, input int budget);
        int k = 0;
        while (got_q.size() < n && k < budget) begin step(); k++; end
        checks++;
        if (got_q.size() < n) begin
            errors++;
            $display("FAIL %s timeout got=%0d words required %0d", name, got_q.size(), n);
        end
    endtask

    task automatic drain_and_compare(input string name, input int budget);
        int k = 0;
        while (got_q.size() < exp_q.size() && k < budget) begin step(); k++; end
        repeat (4) step();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s word_count got=%0d required %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s word%0d got q=%0d e=%b d=%h required q=%0d e=%b d=%h", name, i,
                         got_q[i].qid, got_q[i].eop, got_q[i].data, exp_q[i].qid, exp_q[i].eop, exp_q[i].data);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NQ; i++) begin fwr[i] = 0; frd[i] = 0; end
        q_enable = '1;
        out_ready = 1'b1;
        rand_ready = 1'b0;
        drive();
        step();
        step();
        rst = 1'b0;
        m_last = NQ - 1;
        got_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b required 0", out_valid); end
        checks++; if (out_eop !== 1'b0) begin errors++; $display("FAIL rst_eop got=%b required 0", out_eop); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_data got=%h required 0", out_data); end
        checks++; if (out_qid !== '0) begin errors++; $display("FAIL rst_qid got=%0d required 0", out_qid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b required 0", busy); end
        checks++; if (q_rdreq !== '0) begin errors++; $display("FAIL rst_rdreq got=%b required 0", q_rdreq); end
    endtask

    task automatic test_two_queues();
        do_reset();
        push_pkt(0, 3);
        push_pkt(2, 3);
        model_start();
        build_exp('1);
        drain_and_compare("two_queues", 100);
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].qid !== QW'(i < 3 ? 0 : 2)) begin
                errors++;
                $display("FAIL two_queues_qid%0d got=%0d required %0d", i, got_q[i].qid, i < 3 ? 0 : 2);
            end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int r = 0; r < 3; r++)
            for (int q = 0; q < NQ; q++) push_pkt(q, 1);
        model_start();
        build_exp('1);
        drain_and_compare("round_robin", 200);
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].qid !== QW'(i % NQ)) begin
                errors++;
                $display("FAIL rr_order%0d got=%0d required %0d", i, got_q[i].qid, i % NQ);
            end
        end
    endtask

    task automatic test_stall();
        logic [DWD-1:0] held;
        int             pops;
        do_reset();
        push_pkt(0, 4);
        model_start();
        build_exp('1);
        wait_got("stall_lead", 2, 50);
        out_ready = 1'b0;
        held = out_data;
        pops = 0;
        repeat (5) begin
            step();
            if (last_pop) pops++;
        end
        checks++;
        if (pops != 0 || out_data !== held || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall pops=%0d data=%h valid=%b required 0 %h 1", pops, out_data, out_valid, held);
        end
        checks++;
        if (frd[0] - mrd[0] != 3) begin
            errors++;
            $display("FAIL stall_popped got=%0d required 3", frd[0] - mrd[0]);
        end
        out_ready = 1'b1;
        drain_and_compare("stall", 100);
    endtask

    task automatic test_empty_mid_packet();
        do_reset();
        push_word(1, 1'b0);
        push_word(1, 1'b0);
        push_pkt(3, 2);
        model_start();
        wait_got("empty_lead", 2, 50);
        for (int c = 0; c < 10; c++) begin
            step();
            checks++;
            if (busy !== 1'b1 || last_rq !== '0) begin
                errors++;
                $display("FAIL empty_wait cycle%0d busy=%b rdreq=%b required 1 0", c, busy, last_rq);
            end
        end
        push_word(1, 1'b0);
        push_word(1, 1'b1);
        build_exp('1);
        drain_and_compare("empty_mid", 100);
    endtask

    task automatic test_reset_mid_packet();
        int k = 0;
        do_reset();
        push_pkt(1, 4);
        while (frd[1] < 2 && k < 50) begin step(); k++; end
        checks++;
        if (frd[1] < 2) begin
            errors++;
            $display("FAIL rst_mid_lead timeout popped=%0d required 2", frd[1]);
        end
        rst = 1'b1;
        push_pkt(0, 1);
        step();
        rst = 1'b0;
        m_last = NQ - 1;
        model_start();
        build_exp('1);
        drain_and_compare("rst_mid", 100);
        checks++;
        if (got_q.size() == 0 || got_q[0].qid !== '0) begin
            errors++;
            $display("FAIL rst_mid_first got=%0d words required first from queue 0", got_q.size());
        end
    endtask

    task automatic test_random();
        logic [NQ-1:0] en;
        for (int r = 0; r < 6; r++) begin
            do_reset();
            en = NQ'($urandom_range(1, (1 << NQ) - 1));
            q_enable = en;
            for (int q = 0; q < NQ; q++) begin
                int npk = $urandom_range(0, 3);
                for (int p = 0; p < npk; p++) push_pkt(q, $urandom_range(1, 4));
            end
            model_start();
            build_exp(en);
            rand_ready = 1'b1;
            drain_and_compare("random", 600);
            rand_ready = 1'b0;
            out_ready = 1'b1;
        end
    endtask

`ifdef PTP_BRIDGE_SCHED_STATS_EN
    task automatic test_stats();
        do_reset();
        for (int i = 0; i < 7; i++) push_pkt(3, 1);
        model_start();
        build_exp('1);
        drain_and_compare("stats_a", 100);
        checks++;
        if (pkt_cnt[3*32 +: 32] !== 32'd7) begin
            errors++; $display("FAIL stats_7 got=%0d required 7", pkt_cnt[3*32 +: 32]);
        end
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        checks++;
        if (pkt_cnt[3*32 +: 32] !== 32'd0) begin
            errors++; $display("FAIL stats_clr got=%0d required 0", pkt_cnt[3*32 +: 32]);
        end
        for (int i = 0; i < 2; i++) push_pkt(3, 1);
        model_start();
        build_exp('1);
        drain_and_compare("stats_b", 100);
        checks++;
        if (pkt_cnt[3*32 +: 32] !== 32'd2) begin
            errors++; $display("FAIL stats_2 got=%0d required 2", pkt_cnt[3*32 +: 32]);
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive();
        test_reset();
        test_two_queues();
        test_round_robin();
        test_stall();
        test_empty_mid_packet();
        test_reset_mid_packet();
        test_random();
`ifdef PTP_BRIDGE_SCHED_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
